// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and bit-reverse helper for the FFT result path.
package fft_pkg;

    localparam int FFT_N     = 16;
    localparam int FFT_LOG2N = $clog2(FFT_N);
    localparam int FFT_OUTW  = 48;
    localparam int FFT_DOUTW = 16;
    localparam int FFT_SHIFT = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Reverses the low w bits of a; bits above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] a, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[i[4:0]] = a[5'(w - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_round_sat.sv
// Combinational scale (arithmetic right shift with round-half-up) and clip to OUTW bits.
module fft_round_sat #(
    parameter int INW   = 48,
    parameter int OUTW  = 16,
    parameter int SHIFT = 4
) (
    input  logic [INW-1:0]  x,
    output logic [OUTW-1:0] y,
    output logic            sat
);

    // One extra bit of headroom so adding the rounding constant cannot wrap.
    localparam logic signed [INW:0] RND  = ((INW+1)'(1) << SHIFT) >> 1;
    localparam logic signed [INW:0] MAXV = {{(INW-OUTW+2){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic signed [INW:0] MINV = {{(INW-OUTW+2){1'b1}}, {(OUTW-1){1'b0}}};

    logic signed [INW:0] xe;
    logic signed [INW:0] t;

    assign xe = {x[INW-1], x};
    assign t  = (xe + RND) >>> SHIFT;

    always_comb begin
        y   = '0;
        sat = 1'b0;
        if (t > MAXV) begin
            y   = {1'b0, {(OUTW-1){1'b1}}};
            sat = 1'b1;
        end else if (t < MINV) begin
            y   = {1'b1, {(OUTW-1){1'b0}}};
            sat = 1'b1;
        end else begin
            y = t[OUTW-1:0];
        end
    end

endmodule

// File: rtl/fft_result_serializer.sv
// Latches one FFT frame and streams it out a bin per handshake, rounded and saturated.
// Define BITREV_REORDER_EN to read the bank in bit-reversed (natural-frequency) order.
module fft_result_serializer
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int OUTW  = FFT_OUTW,
    parameter int DOUTW = FFT_DOUTW,
    parameter int SHIFT = FFT_SHIFT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    input  logic [N*OUTW-1:0]     yr_flat,
    input  logic [N*OUTW-1:0]     yi_flat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUTW-1:0]      out_re,
    output logic [DOUTW-1:0]      out_im,
    output logic [$clog2(N)-1:0]  out_bin,
    output logic                  out_last,
    output logic                  out_sat,
    output logic                  busy
);

    localparam int LOG2N = $clog2(N);

    state_t                 state, state_nx;
    logic [N-1:0][OUTW-1:0] bank_re, bank_im;
    logic [LOG2N-1:0]       rd_idx, addr;
    logic                   accept, adv, streaming, at_last;
    logic [DOUTW-1:0]       re_q, im_q;
    logic                   sat_re, sat_im;

    assign streaming = (state == STREAM);
    assign at_last   = (rd_idx == LOG2N'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        adv      = 1'b0;
        case (state)
            IDLE: begin
                if (frame_valid) begin
                    accept   = 1'b1;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    adv = 1'b1;
                    if (at_last) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // rd_idx wraps to zero on the final handshake since N is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_re <= '0;
            bank_im <= '0;
            rd_idx  <= '0;
        end else if (accept) begin
            bank_re <= yr_flat;
            bank_im <= yi_flat;
            rd_idx  <= '0;
        end else if (adv) begin
            rd_idx  <= rd_idx + 1'b1;
        end
    end

`ifdef BITREV_REORDER_EN
    assign addr = LOG2N'(bitrev(32'(rd_idx), LOG2N));
`else
    assign addr = rd_idx;
`endif

    fft_round_sat #(.INW(OUTW), .OUTW(DOUTW), .SHIFT(SHIFT)) u_rs_re (
        .x   (bank_re[addr]),
        .y   (re_q),
        .sat (sat_re)
    );

    fft_round_sat #(.INW(OUTW), .OUTW(DOUTW), .SHIFT(SHIFT)) u_rs_im (
        .x   (bank_im[addr]),
        .y   (im_q),
        .sat (sat_im)
    );

    // Outputs are forced to zero outside STREAM so idle/reset values are clean.
    assign frame_ready = (state == IDLE) && !rst;
    assign out_valid   = streaming;
    assign busy        = streaming;
    assign out_re      = streaming ? re_q : '0;
    assign out_im      = streaming ? im_q : '0;
    assign out_bin     = streaming ? addr : '0;
    assign out_last    = streaming && at_last;
    assign out_sat     = streaming && (sat_re || sat_im);

endmodule

// File: tb/tb_fft_result_serializer.sv
// Randomized bench for fft_result_serializer against an integer round/clip/order model.
module tb_fft_result_serializer;

    localparam int N     = 16;
    localparam int LOG2N = 4;
    localparam int OUTW  = 48;
    localparam int DOUTW = 16;
    localparam int SHIFT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_valid;
    logic              frame_ready;
    logic [N*OUTW-1:0] yr_flat, yi_flat;
    logic              out_valid, out_ready;
    logic [DOUTW-1:0]  out_re, out_im;
    logic [LOG2N-1:0]  out_bin;
    logic              out_last, out_sat, busy;

    int     n_chk = 0;
    int     n_err = 0;
    longint yr[N], yi[N];
    longint ex_r[N], ex_i[N];

    always #5 clk = ~clk;

    fft_result_serializer #(.N(N), .OUTW(OUTW), .DOUTW(DOUTW), .SHIFT(SHIFT)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .yr_flat     (yr_flat),
        .yi_flat     (yi_flat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_re      (out_re),
        .out_im      (out_im),
        .out_bin     (out_bin),
        .out_last    (out_last),
        .out_sat     (out_sat),
        .busy        (busy)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scale by 2^SHIFT with round-half-up, then clip to the signed DOUTW range.
    function automatic longint model_val(input longint x, output bit clipped);
        longint t, hi, lo;
        t  = (x + (longint'(1) <<< SHIFT) / 2) >>> SHIFT;
        hi = (longint'(1) <<< (DOUTW - 1)) - 1;
        lo = -(longint'(1) <<< (DOUTW - 1));
        clipped = (t > hi) || (t < lo);
        return (t > hi) ? hi : (t < lo) ? lo : t;
    endfunction

    function automatic int read_order(input int j);
        int r;
        r = j;
`ifdef BITREV_REORDER_EN
        r = 0;
        for (int b = 0; b < LOG2N; b++) r = r * 2 + ((j >> b) & 1);
`endif
        return r;
    endfunction

    function automatic longint rnd48();
        longint v;
        v = {$urandom, $urandom};
        return (v <<< 16) >>> 16;
    endfunction

    function automatic longint rnd_small();
        return longint'($urandom_range(0, 1 << 21)) - (longint'(1) << 20);
    endfunction

    // kind 0: ramp, 1: rounding/saturation corners, 2: near-range random, 3: full-width random
    task automatic fill(input int kind);
        for (int k = 0; k < N; k++) begin
            case (kind)
                0:       begin yr[k] = 16 * k;      yi[k] = -16 * k;     end
                3:       begin yr[k] = rnd48();     yi[k] = rnd48();     end
                default: begin yr[k] = rnd_small(); yi[k] = rnd_small(); end
            endcase
        end
        if (kind == 1) begin
            yr[0] = 24; yr[1] = -24; yr[2] = 7; yr[3] = 8;
            yi[0] = -8; yi[1] = -9;  yi[2] = 0; yi[3] = -7;
            yr[5] = longint'(1) << 20;
            yi[5] = -(longint'(1) << 20);
            for (int k = 6; k < N; k++) begin
                yr[k] = longint'($urandom_range(0, 1000)) - 500;
                yi[k] = longint'($urandom_range(0, 1000)) - 500;
            end
            yr[4] = 100; yi[4] = -100;
        end
    endtask

    task automatic drive_flat();
        for (int k = 0; k < N; k++) begin
            yr_flat[k*OUTW +: OUTW] = yr[k][OUTW-1:0];
            yi_flat[k*OUTW +: OUTW] = yi[k][OUTW-1:0];
        end
    endtask

    // Entered and left between a negedge and the following posedge.
    task automatic send_frame();
        int w;
        w = 0;
        drive_flat();
        frame_valid = 1'b1;
        while (!frame_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("accept_timeout", 0, 1);
        ex_r = yr;
        ex_i = yi;
        @(negedge clk);
        frame_valid = 1'b0;
        chk("latency_valid", out_valid, 1);
        chk("latency_bin", longint'(out_bin), read_order(0));
    endtask

    // mode 0: ready high, 1: pattern 1,0,0,..., 2: random ready. abort_at < N resets mid-stream.
    task automatic stream(input int mode, input int abort_at);
        int     j, cyc, a;
        longint er, ei;
        bit     sr, si;
        j = 0;
        cyc = 0;
        while (j < N && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = $urandom_range(0, 1);
            endcase
            if (j == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_ready", frame_ready, 0);
                @(negedge clk);
                rst = 1'b0;
                out_ready = 1'b0;
                #1;
                chk("post_abort_ready", frame_ready, 1);
                chk("post_abort_valid", out_valid, 0);
                return;
            end
            a  = read_order(j);
            er = model_val(ex_r[a], sr);
            ei = model_val(ex_i[a], si);
            chk("valid", out_valid, 1);
            chk("busy", busy, 1);
            chk("ready_in_stream", frame_ready, 0);
            chk("re", longint'($signed(out_re)), er);
            chk("im", longint'($signed(out_im)), ei);
            chk("bin", longint'(out_bin), a);
            chk("last", out_last, (j == N - 1));
            chk("sat", out_sat, (sr || si));
            if (out_ready) j++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 400) chk("stream_timeout", 0, 1);
        out_ready = 1'b0;
        chk("end_valid", out_valid, 0);
        chk("end_ready", frame_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        frame_valid = 1'b0;
        out_ready = 1'b0;
        yr_flat = '0;
        yi_flat = '0;
        repeat (2) @(negedge clk);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_re", longint'(out_re), 0);
        chk("rst_im", longint'(out_im), 0);
        chk("rst_bin", longint'(out_bin), 0);
        chk("rst_last", out_last, 0);
        chk("rst_sat", out_sat, 0);
        rst = 1'b0;
        #1;
        chk("idle_ready", frame_ready, 1);

        fill(0); send_frame(); stream(0, N);
        fill(0); send_frame(); stream(1, N);
        fill(1); send_frame(); stream(2, N);

        // Next frame held on the bus during streaming; accepted right after the last beat.
        fill(2); send_frame();
        fill(3); drive_flat(); frame_valid = 1'b1;
        stream(0, N);
        send_frame(); stream(2, N);

        fill(2); send_frame(); stream(0, 7);
        fill(3); send_frame(); stream(2, N);

        for (int r = 0; r < 6; r++) begin
            fill(2 + (r % 2));
            send_frame();
            stream(r % 3, N);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fft_result_serializer.md
Name: fft_result_serializer

Overview:
- Output-side counterpart to the input sample loader.
- Accepts one complete stage-2 FFT frame as flattened real/imag vectors (N bins × OUTW bits) via a valid/ready handshake and latches it into a frame register bank.
- Streams the frame out one bin per handshake as rounded, saturated DOUTW-bit complex samples, tagged with bin index and last-bin flag.
- Sits between stage2 results and downstream consumers (UART/DMA/testbench sink).

Parameters:
- N, 16, FFT points / bins per frame (power of 2).
- OUTW, 48, width of each input bin component (stage2 accumulator width).
- DOUTW, 16, width of each streamed output component.
- SHIFT, 4, right-shift applied before rounding (scaling), 0..OUTW-DOUTW.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- frame_valid  in  1  input frame present on flat buses.
- frame_ready  out  1  block can accept a frame.
- yr_flat  in  N*OUTW  signed real bins; bin k at [(k+1)*OUTW-1 : k*OUTW].
- yi_flat  in  N*OUTW  signed imaginary bins, same packing.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts sample.
- out_re  out  DOUTW  signed real sample.
- out_im  out  DOUTW  signed imaginary sample.
- out_bin  out  log2(N)  bin index of current sample.
- out_last  out  1  current sample is final of frame.
- out_sat  out  1  out_re or out_im saturated for current sample.
- busy  out  1  frame held / streaming.

Behaviour:
- Reset (async, rst=1): state=IDLE, frame bank cleared to 0, rd_idx=0; frame_ready=0 while rst high; out_valid=0, out_re=0, out_im=0, out_bin=0, out_last=0, out_sat=0, busy=0.
- FSM IDLE:
  - frame_ready=1, out_valid=0.
  - frame_valid & frame_ready at edge: latch all 2N bins, rd_idx=0, go STREAM.
- FSM STREAM:
  - frame_ready=0, busy=1, out_valid=1.
  - out_* derived only from registered bank and rd_idx; no combinational path from inputs or out_ready.
  - Latency: out_valid high the cycle after frame acceptance, presenting bin 0.
  - Handshake out_valid & out_ready: rd_idx increments.
  - On handshake with rd_idx==N-1: return to IDLE; rd_idx=0, out_valid=0 next cycle.
  - out_ready low: out_re/out_im/out_bin/out_last/out_sat held stable.
- out_last = (rd_idx==N-1) while in STREAM.
- Arithmetic per component x: t = (x + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, round half toward +inf; SHIFT=0 means no rounding. Compute in OUTW+1 bits to avoid overflow.
- Saturation: t > 2^(DOUTW-1)-1 gives max positive; t < -2^(DOUTW-1) gives min negative. out_sat=1 if either component clipped.
- Throughput: one bin per cycle with out_ready held high; N cycles per frame plus 1 idle cycle before the next accept.
- frame_valid during STREAM is ignored (not latched). The producer holds it, and it is accepted in the IDLE cycle after the last handshake.
- Frame_valid asserted with out_ready low throughout: the frame is still accepted; the stream stalls at bin 0.
- rst asserted mid-stream: immediate abort to reset values; the partial frame is discarded.

Optional Feature:
- BITREV_REORDER_EN defined: read address = bit-reverse(rd_idx) over log2(N) bits. out_bin reports the bit-reversed (natural-frequency) index, so bins stream in order 0,8,4,12,2,… for N=16.
- Undefined: read address = rd_idx; out_bin = rd_idx; natural storage order.
- out_last is always tied to the rd_idx count, never to out_bin.

Decomposition:
- Package fft_pkg: FFT_N, FFT_LOG2N, OUTW/DOUTW defaults, state enum localparams (IDLE, STREAM), bitrev function.
- Sub-module fft_round_sat (params INW, OUTW, SHIFT): combinational round + saturate + sat flag; instantiated twice (re, im).

Test Plan:
- Reset then frame with yr[k]=16k, yi[k]=-16k, out_ready=1 -> 16 consecutive beats with out_re=k, out_im=-k, out_bin=k, out_last only at k=15, out_sat=0, then frame_ready=1.
- Backpressure: same frame, out_ready toggling 1,0,0,1,… -> each beat held stable while out_ready=0; no bin skipped or duplicated; 16 beats total.
- Rounding: yr[0]=24, yr[1]=-24, yr[2]=7, yr[3]=8 (SHIFT=4) -> out_re 2, -1, 0, 1.
- Saturation: yr[5]=2^20, yi[5]=-2^20 -> out_re=32767, out_im=-32768, out_sat=1 on bin 5 only.
- Back-to-back frames: frame_valid held high with second frame during streaming -> second frame accepted exactly one cycle after first out_last handshake; mid-stream rst at bin 7 -> out_valid=0 immediately, frame_ready=1 after release.
- BITREV_REORDER_EN defined, yr[k]=16k -> out_bin/out_re sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
